// File: rtl/div_freq.sv
// Enable-gated clock divider: BCLK toggles after every HALF_PERIOD enabled CLK edges.
// Phase is held while EN_CLK is low; BCLK comes straight from a flop.
module div_freq #(
  parameter int HALF_PERIOD = 4,
  parameter int CNT_W       = (HALF_PERIOD <= 1) ? 1 : $clog2(HALF_PERIOD)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN_CLK,
  output logic BCLK
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             term;

  assign term = (cnt_q == TERM_CNT);

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (EN_CLK) begin
      // Wrap only at the terminal count so cnt never passes HALF_PERIOD-1.
      if (term) begin
        cnt_d  = '0;
        bclk_d = ~bclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign BCLK = bclk_q;

endmodule

// File: tb/tb_div_freq.sv
// Bench for div_freq: HALF_PERIOD=4 and HALF_PERIOD=1 instances against an
// enabled-edge-count model (bclk = (n / HP) mod 2, cnt = n mod HP).
module tb_div_freq;

  localparam int HP  = 4;
  localparam int HP1 = 1;

  logic clk;
  logic rst;
  logic en;
  logic en1;
  logic bclk;
  logic bclk1;

  int tests_run;
  int tests_failed;

  // Model state: enabled edges since the last reset, per instance.
  int n4;
  int n1;
  logic [31:0] exp_q[$];
  int toggles;
  int en_edges;
  logic prev_bclk;

  div_freq #(.HALF_PERIOD(HP)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .EN_CLK (en),
    .BCLK   (bclk)
  );

  div_freq #(.HALF_PERIOD(HP1)) dut1 (
    .CLK    (clk),
    .RESET  (rst),
    .EN_CLK (en1),
    .BCLK   (bclk1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: apply inputs, take one edge, advance model, check outputs.
  task automatic step(input logic r, input logic e, input logic e1);
    logic [31:0] exp_bclk;
    rst = r;
    en  = e;
    en1 = e1;
    @(posedge clk);
    if (r) begin
      n4 = 0;
      n1 = 0;
    end else begin
      if (e)  n4++;
      if (e1) n1++;
    end
    #0.5;
    exp_q.push_back(32'((n4 / HP) % 2));
    exp_q.push_back(32'(n4 % HP));
    exp_q.push_back(32'((n1 / HP1) % 2));
    exp_bclk = exp_q.pop_front();
    check("bclk_hp4", 32'(bclk), exp_bclk);
    check("cnt_hp4", 32'(dut.cnt_q), exp_q.pop_front());
    check("bclk_hp1", 32'(bclk1), exp_q.pop_front());
    if (dut.cnt_q >= 2'(HP - 1) + 2'd1 && HP < 4) check("cnt_range", 32'(dut.cnt_q), 32'(HP - 1));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n4 = 0;
    n1 = 0;
    rst = 1'b1;
    en  = 1'b0;
    en1 = 1'b0;

    // Reset held with both enable values, then released with enable low.
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    check("reset_bclk", 32'(bclk), 32'd0);
    repeat (5) step(0, 0, 0);
    check("idle_bclk", 32'(bclk), 32'd0);

    // Continuous enable for 4 full periods; also HP=1 toggles every edge.
    for (int i = 1; i <= 32; i++) begin
      step(0, 1, 1);
      if (i == 4) check("first_rise", 32'(bclk), 32'd1);
      if (i == 8) check("first_fall", 32'(bclk), 32'd0);
    end
    // HP=1 freeze with enable low.
    step(0, 1, 1);
    prev_bclk = bclk1;
    repeat (3) step(0, 0, 0);
    check("hp1_freeze", 32'(bclk1), 32'(prev_bclk));

    // Enable gap: rise at edge 4, hold through gap, fall on 3rd re-enabled edge.
    step(1, 0, 0);
    repeat (5) step(0, 1, 0);
    check("gap_high", 32'(bclk), 32'd1);
    check("gap_cnt", 32'(dut.cnt_q), 32'd1);
    repeat (5) step(0, 0, 0);
    check("gap_hold", 32'(bclk), 32'd1);
    step(0, 1, 0);
    step(0, 1, 0);
    check("gap_not_yet", 32'(bclk), 32'd1);
    step(0, 1, 0);
    check("gap_fall", 32'(bclk), 32'd0);

    // Reset mid-high: bclk=1, cnt=2, then reset with enable high.
    step(1, 0, 0);
    repeat (6) step(0, 1, 0);
    check("mid_high", 32'(bclk), 32'd1);
    step(1, 1, 0);
    check("mid_reset", 32'(bclk), 32'd0);
    repeat (3) step(0, 1, 0);
    check("post_rst_low", 32'(bclk), 32'd0);
    step(0, 1, 0);
    check("post_rst_rise", 32'(bclk), 32'd1);

    // Long random run: toggle count equals floor(enabled edges / HP).
    step(1, 0, 0);
    toggles   = 0;
    en_edges  = 0;
    prev_bclk = bclk;
    for (int i = 0; i < 250; i++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      step(0, e, 1'($urandom_range(0, 1)));
      if (e) en_edges++;
      if (bclk !== prev_bclk) toggles++;
      prev_bclk = bclk;
      if (dut.cnt_q > 2'(HP - 1)) check("cnt_bound", 32'(dut.cnt_q), 32'(HP - 1));
    end
    check("toggle_count", 32'(toggles), 32'(en_edges / HP));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
